// File: rtl/packed_array_dump.sv
// Packed WA x WB register array with masked writes and an ordered,
// handshaked element-by-element dump of the whole array.
module packed_array_dump #(
  parameter int unsigned WA    = 8,
  parameter int unsigned WB    = 8,
  parameter bit          ORDER = 1'b0,
  localparam int unsigned AW   = $clog2(WA)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_vld,
  output logic                wr_rdy,
  input  logic                wr_all,
  input  logic [AW-1:0]       wr_idx,
  input  logic [WB-1:0]       wr_msk,
  input  logic [WB-1:0]       wr_dat,
  output logic                wr_err,
  input  logic                clr,
  input  logic                dmp_req,
  output logic                busy,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [WB-1:0]       out_dat,
  output logic [AW-1:0]       out_idx,
  output logic                out_lst,
  output logic [WA*WB-1:0]    arr
);

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  // First and final element index of a dump for the selected order.
  localparam logic [AW-1:0] FIRST = ORDER ? AW'(WA - 1) : AW'(0);
  localparam logic [AW-1:0] LAST  = ORDER ? AW'(0) : AW'(WA - 1);
  localparam logic [AW:0]   WA_EXT = (AW + 1)'(WA);

  state_t                 state_q;
  state_t                 state_d;
  logic [AW-1:0]          cnt_q;
  logic [AW-1:0]          cnt_d;
  logic [WA-1:0][WB-1:0]  mem;
  logic                   wr_acc;
  logic                   idx_ok;
  logic                   hs;

  // Handshake and status decode, all derived from registered state.
  assign wr_rdy  = (state_q == IDLE);
  assign busy    = (state_q == DUMP);
  assign out_vld = busy;
  assign out_idx = cnt_q;
  assign out_dat = mem[cnt_q];
  assign out_lst = busy && (cnt_q == LAST);
  assign arr     = mem;

  assign hs     = out_vld && out_rdy;
  assign wr_acc = wr_vld && wr_rdy && !clr;
  assign idx_ok = ({1'b0, wr_idx} < WA_EXT);

  // State and dump pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and pointer stepping; clear overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dmp_req) begin
            state_d = DUMP;
            cnt_d   = FIRST;
          end
        end
        DUMP: begin
          if (hs) begin
            if (cnt_q == LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (ORDER) begin
              cnt_d = cnt_q - AW'(1);
            end else begin
              cnt_d = cnt_q + AW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Array storage: masked read-modify-write of one or all elements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (wr_acc) begin
      for (int unsigned e = 0; e < WA; e++) begin
        if (wr_all || (wr_idx == AW'(e))) begin
          mem[e] <= (mem[e] & ~wr_msk) | (wr_dat & wr_msk);
        end
      end
    end
  end

  // One-cycle error pulse for an accepted single-element write out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_acc && !wr_all && !idx_ok;
    end
  end

endmodule

// File: tb/tb_packed_array_dump.sv
// Scoreboard bench for packed_array_dump: three instances (WA=8 ascending,
// WA=8 descending, WA=6 ascending) share one stimulus stream.
module tb_packed_array_dump;

  logic        clk;
  logic        rst_n;
  logic        wr_vld;
  logic        wr_all;
  logic [2:0]  wr_idx;
  logic [7:0]  wr_msk;
  logic [7:0]  wr_dat;
  logic        clr;
  logic        dmp_req;
  logic        out_rdy;

  logic        a_wr_rdy, a_wr_err, a_busy, a_out_vld, a_out_lst;
  logic [7:0]  a_out_dat;
  logic [2:0]  a_out_idx;
  logic [63:0] a_arr;
  logic        b_wr_rdy, b_wr_err, b_busy, b_out_vld, b_out_lst;
  logic [7:0]  b_out_dat;
  logic [2:0]  b_out_idx;
  logic [63:0] b_arr;
  logic        c_wr_rdy, c_wr_err, c_busy, c_out_vld, c_out_lst;
  logic [7:0]  c_out_dat;
  logic [2:0]  c_out_idx;
  logic [47:0] c_arr;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m8 [8];
  logic [7:0]  m6 [6];
  logic [11:0] q_a [$];
  logic [11:0] q_b [$];
  logic [11:0] q_c [$];

  packed_array_dump #(.WA(8), .WB(8), .ORDER(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(a_wr_rdy), .wr_all(wr_all),
    .wr_idx(wr_idx), .wr_msk(wr_msk), .wr_dat(wr_dat), .wr_err(a_wr_err), .clr(clr),
    .dmp_req(dmp_req), .busy(a_busy), .out_vld(a_out_vld), .out_rdy(out_rdy),
    .out_dat(a_out_dat), .out_idx(a_out_idx), .out_lst(a_out_lst), .arr(a_arr)
  );

  packed_array_dump #(.WA(8), .WB(8), .ORDER(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(b_wr_rdy), .wr_all(wr_all),
    .wr_idx(wr_idx), .wr_msk(wr_msk), .wr_dat(wr_dat), .wr_err(b_wr_err), .clr(clr),
    .dmp_req(dmp_req), .busy(b_busy), .out_vld(b_out_vld), .out_rdy(out_rdy),
    .out_dat(b_out_dat), .out_idx(b_out_idx), .out_lst(b_out_lst), .arr(b_arr)
  );

  packed_array_dump #(.WA(6), .WB(8), .ORDER(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(c_wr_rdy), .wr_all(wr_all),
    .wr_idx(wr_idx), .wr_msk(wr_msk), .wr_dat(wr_dat), .wr_err(c_wr_err), .clr(clr),
    .dmp_req(dmp_req), .busy(c_busy), .out_vld(c_out_vld), .out_rdy(out_rdy),
    .out_dat(c_out_dat), .out_idx(c_out_idx), .out_lst(c_out_lst), .arr(c_arr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it when observed differs from expected.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack8();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m8[i];
    return r;
  endfunction

  function automatic logic [47:0] pack6();
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = m6[i];
    return r;
  endfunction

  task automatic model_write(input logic all, input logic [2:0] idx, input logic [7:0] msk,
                             input logic [7:0] dat, output logic err6);
    for (int i = 0; i < 8; i++)
      if (all || idx == 3'(i)) m8[i] = (m8[i] & ~msk) | (dat & msk);
    for (int i = 0; i < 6; i++)
      if (all || idx == 3'(i)) m6[i] = (m6[i] & ~msk) | (dat & msk);
    err6 = !all && (idx >= 3'd6);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m8[i] = 8'h00;
    for (int i = 0; i < 6; i++) m6[i] = 8'h00;
  endtask

  task automatic do_write(input logic all, input logic [2:0] idx, input logic [7:0] msk,
                          input logic [7:0] dat);
    logic e6;
    cyc();
    wr_vld = 1'b1; wr_all = all; wr_idx = idx; wr_msk = msk; wr_dat = dat;
    cyc();
    wr_vld = 1'b0; wr_all = 1'b0;
    model_write(all, idx, msk, dat, e6);
    @(negedge clk);
    check_eq("wr_arr_a", a_arr, pack8());
    check_eq("wr_arr_b", b_arr, pack8());
    check_eq("wr_arr_c", 64'(c_arr), 64'(pack6()));
    check_eq("wr_err_a", 64'(a_wr_err), 64'(0));
    check_eq("wr_err_c", 64'(c_wr_err), 64'(e6));
  endtask

  task automatic do_clr();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("clr_arr_a", a_arr, 64'(0));
    check_eq("clr_arr_c", 64'(c_arr), 64'(0));
  endtask

  task automatic start_dump(input logic with_wr, input logic [2:0] idx, input logic [7:0] dat);
    logic e6;
    cyc();
    dmp_req = 1'b1;
    if (with_wr) begin
      wr_vld = 1'b1; wr_all = 1'b0; wr_idx = idx; wr_msk = 8'hFF; wr_dat = dat;
    end
    cyc();
    dmp_req = 1'b0;
    wr_vld  = 1'b0;
    if (with_wr) model_write(1'b0, idx, 8'hFF, dat, e6);
    for (int i = 0; i < 8; i++) q_a.push_back({m8[i], 3'(i), i == 7});
    for (int i = 7; i >= 0; i--) q_b.push_back({m8[i], 3'(i), i == 0});
    for (int i = 0; i < 6; i++) q_c.push_back({m6[i], 3'(i), i == 5});
  endtask

  task automatic wait_idle(output int ca, output int cb, output int cc);
    ca = 0; cb = 0; cc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!a_busy && !b_busy && !c_busy) break;
      ca += int'(a_busy);
      cb += int'(b_busy);
      cc += int'(c_busy);
    end
    check_eq("dump_done", 64'({a_busy, b_busy, c_busy}), 64'(0));
    check_eq("q_a_empty", 64'(q_a.size()), 64'(0));
    check_eq("q_b_empty", 64'(q_b.size()), 64'(0));
    check_eq("q_c_empty", 64'(q_c.size()), 64'(0));
  endtask

  task automatic flush_queues();
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  // Scoreboard monitors: each handshake pops and compares {dat, idx, lst}.
  always @(negedge clk) begin : mon_a
    logic [11:0] e;
    if (rst_n && !clr && a_out_vld && out_rdy) begin
      if (q_a.size() == 0) check_eq("a_extra_elem", 64'(1), 64'(0));
      else begin
        e = q_a.pop_front();
        check_eq("a_elem", 64'({a_out_dat, a_out_idx, a_out_lst}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [11:0] e;
    if (rst_n && !clr && b_out_vld && out_rdy) begin
      if (q_b.size() == 0) check_eq("b_extra_elem", 64'(1), 64'(0));
      else begin
        e = q_b.pop_front();
        check_eq("b_elem", 64'({b_out_dat, b_out_idx, b_out_lst}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [11:0] e;
    if (rst_n && !clr && c_out_vld && out_rdy) begin
      if (q_c.size() == 0) check_eq("c_extra_elem", 64'(1), 64'(0));
      else begin
        e = q_c.pop_front();
        check_eq("c_elem", 64'({c_out_dat, c_out_idx, c_out_lst}), 64'(e));
      end
    end
  end

  initial begin
    int  ca, cb, cc;
    logic hit;
    rst_n = 1'b0; wr_vld = 1'b0; wr_all = 1'b0; wr_idx = 3'd0; wr_msk = 8'h00;
    wr_dat = 8'h00; clr = 1'b0; dmp_req = 1'b0; out_rdy = 1'b1;
    model_clear();

    // Reset state
    #3;
    check_eq("rst_arr", a_arr, 64'(0));
    check_eq("rst_busy", 64'(a_busy), 64'(0));
    check_eq("rst_out_vld", 64'(a_out_vld), 64'(0));
    check_eq("rst_out_lst", 64'(a_out_lst), 64'(0));
    check_eq("rst_out_idx_b", 64'(b_out_idx), 64'(0));
    check_eq("rst_wr_err", 64'(a_wr_err), 64'(0));
    check_eq("rst_wr_rdy", 64'(a_wr_rdy), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Broadcast write, then clear
    do_write(1'b1, 3'd0, 8'hFF, 8'hFF);
    check_eq("all_ones", a_arr, 64'hFFFF_FFFF_FFFF_FFFF);
    do_clr();

    // Masked single-element writes; idx 7 is out of range for WA=6
    do_write(1'b0, 3'd7, 8'hF0, 8'hAB);
    check_eq("hi_nibble", a_arr, 64'hA000_0000_0000_0000);
    do_write(1'b0, 3'd0, 8'h0F, 8'h5C);
    check_eq("lo_nibble", a_arr, 64'hA000_0000_0000_000C);
    do_write(1'b0, 3'd3, 8'h00, 8'h77);

    // Load element i = i+1, then dump with consumer always ready
    for (int i = 0; i < 8; i++) do_write(1'b0, 3'(i), 8'hFF, 8'(i + 1));
    start_dump(1'b0, 3'd0, 8'h00);
    wait_idle(ca, cb, cc);
    check_eq("len_a", 64'(ca), 64'(8));
    check_eq("len_b", 64'(cb), 64'(8));
    check_eq("len_c", 64'(cc), 64'(6));
    check_eq("rdy_after_dump", 64'(a_wr_rdy), 64'(1));

    // Backpressure at element 3 with a blocked write attempt
    start_dump(1'b0, 3'd0, 8'h00);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      cyc();
      if (a_out_vld && a_out_idx == 3'd3) begin
        out_rdy = 1'b0;
        wr_vld = 1'b1; wr_all = 1'b1; wr_msk = 8'hFF; wr_dat = 8'hEE;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_eq("stall_dat", 64'(a_out_dat), 64'(8'h04));
          check_eq("stall_idx", 64'(a_out_idx), 64'(3));
          check_eq("stall_vld", 64'(a_out_vld), 64'(1));
          check_eq("stall_wr_rdy", 64'(a_wr_rdy), 64'(0));
          cyc();
        end
        out_rdy = 1'b1;
        wr_vld = 1'b0; wr_all = 1'b0;
        hit = 1'b1;
      end
    end
    check_eq("stall_reached", 64'(hit), 64'(1));
    wait_idle(ca, cb, cc);
    check_eq("blocked_arr_a", a_arr, pack8());
    check_eq("blocked_arr_c", 64'(c_arr), 64'(pack6()));
    check_eq("blocked_err", 64'(a_wr_err), 64'(0));

    // Write and dump request in the same cycle
    start_dump(1'b1, 3'd2, 8'h33);
    wait_idle(ca, cb, cc);
    check_eq("same_cycle_arr", 64'(a_arr[23:16]), 64'(8'h33));

    // Clear at the fourth element of a dump
    start_dump(1'b0, 3'd0, 8'h00);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      cyc();
      if (a_out_vld && a_out_idx == 3'd3) begin
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        hit = 1'b1;
      end
    end
    check_eq("clr_reached", 64'(hit), 64'(1));
    @(negedge clk);
    model_clear();
    flush_queues();
    check_eq("clr_out_vld", 64'(a_out_vld), 64'(0));
    check_eq("clr_out_vld_b", 64'(b_out_vld), 64'(0));
    check_eq("clr_busy", 64'(a_busy), 64'(0));
    check_eq("clr_idx", 64'(a_out_idx), 64'(0));
    check_eq("clr_wr_rdy", 64'(a_wr_rdy), 64'(1));
    check_eq("clr_dump_arr", a_arr, 64'(0));
    check_eq("clr_dump_arr_c", 64'(c_arr), 64'(0));

    // Asynchronous reset in the middle of a dump
    do_write(1'b1, 3'd0, 8'hFF, 8'h5A);
    start_dump(1'b0, 3'd0, 8'h00);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(a_busy), 64'(0));
    check_eq("arst_out_vld", 64'(a_out_vld), 64'(0));
    check_eq("arst_out_lst", 64'(a_out_lst), 64'(0));
    check_eq("arst_out_idx", 64'(a_out_idx), 64'(0));
    check_eq("arst_arr", a_arr, 64'(0));
    check_eq("arst_wr_rdy", 64'(a_wr_rdy), 64'(1));
    check_eq("arst_busy_b", 64'(b_busy), 64'(0));
    flush_queues();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_idle", 64'({a_busy, b_busy, c_busy}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
